framebuffer_writer: RTL and testbench

- Downstream of the rasterizer/clear stage; consumes its pixel stream (address, 3-bit colour, write strobe) and drives the framebuffer memory write port.
- Buffers pixels in a small FIFO so framebuffer memory can backpressure.
- Maps each pixel into one of two framebuffers (double buffering).
- Qualifies frame-done so the display only flips after the last pixel is committed.

---
 rtl/illusion_pkg.sv | 22 ++
 rtl/framebuffer_writer_if.sv | 27 ++
 rtl/framebuffer_writer_pixel_fifo.sv | 55 +++++
 rtl/framebuffer_writer.sv | 127 ++++++++++++
 tb/tb_framebuffer_writer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/illusion_pkg.sv
// Shared constants and types for the framebuffer writer: frame geometry, pixel
// entry layout and the frame-completion state encoding.
package illusion_pkg;

   localparam int RENDERING_WIDTH       = 320;
   localparam int RENDERING_HEIGHT      = 240;
   localparam int FB_SIZE               = RENDERING_WIDTH * RENDERING_HEIGHT;
   localparam int PIXEL_WIDTH           = 3;
   localparam int FB_ADDR_WIDTH_DEFAULT = 18;

   typedef enum logic [1:0] {
      DRAWING  = 2'd0,
      DRAINING = 2'd1,
      DONE     = 2'd2
   } frame_state_t;

   typedef struct packed {
      logic [FB_ADDR_WIDTH_DEFAULT-1:0] addr;
      logic [PIXEL_WIDTH-1:0]           data;
   } pixel_entry_t;

endpackage

// File: rtl/framebuffer_writer_if.sv
// Pixel stream from the rasterizer plus the framebuffer memory write port.
// The writer is the slave; the upstream stage / memory model is the master.
interface framebuffer_writer_if #(
   parameter int FB_ADDR_WIDTH = 18
);
   import illusion_pkg::*;

   logic [31:0]              aPixelAddr;
   logic [PIXEL_WIDTH-1:0]   aPixelData;
   logic                     aPixelWrite;
   logic                     anOutStall;
   logic [FB_ADDR_WIDTH-1:0] anOutFbAddr;
   logic [PIXEL_WIDTH-1:0]   anOutFbData;
   logic                     anOutFbWrite;
   logic                     aFbReady;

   modport master (
      output aPixelAddr, aPixelData, aPixelWrite, aFbReady,
      input  anOutStall, anOutFbAddr, anOutFbData, anOutFbWrite
   );

   modport slave (
      input  aPixelAddr, aPixelData, aPixelWrite, aFbReady,
      output anOutStall, anOutFbAddr, anOutFbData, anOutFbWrite
   );

endinterface

// File: rtl/framebuffer_writer_pixel_fifo.sv
// Small synchronous FIFO holding pixels between the rasterizer and memory.
// Storage is not reset; only pointers and the occupancy count are.
module pixel_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 21,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [CNT_W-1:0] count_q;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rdPtr_q];
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/framebuffer_writer.sv
// Buffers rasterized pixels, maps them into one of two framebuffers and only
// reports frame-done once every pixel of the frame has been written to memory.
module framebuffer_writer #(
   parameter int FIFO_DEPTH       = 8,
   parameter int RENDERING_WIDTH  = 320,
   parameter int RENDERING_HEIGHT = 240,
   parameter int FB_ADDR_WIDTH    = 18
) (
   input  logic                 aClock,
   input  logic                 aReset,
   framebuffer_writer_if.slave  bus,
   input  logic                 aFrameDone,
   input  logic                 aFrameFlipped,
   output logic                 anOutFrameDone,
   output logic                 anOutBufferSelect,
   output logic                 anOutAddrError
);
   import illusion_pkg::*;

   localparam int FRAME_PIXELS = RENDERING_WIDTH * RENDERING_HEIGHT;
   localparam int ENTRY_W      = $bits(pixel_entry_t);
   localparam int ENTRY_ADDR_W = ENTRY_W - PIXEL_WIDTH;
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [FB_ADDR_WIDTH-1:0] BANK_OFFSET = FB_ADDR_WIDTH'(FRAME_PIXELS);

   frame_state_t             state_q, state_d;
   logic                     bufferSelect_q, bufferSelect_d;
   logic                     errorFlag_q, errorFlag_d;
   logic                     slotValid_q, slotValid_d;
   pixel_entry_t             slot_q, slot_d;

   pixel_entry_t             pushEntry;
   pixel_entry_t             headEntry;
   logic [FB_ADDR_WIDTH-1:0] bankAddr;
   logic                     inRange;
   logic                     pushReq;
   logic                     dropPixel;
   logic                     slotFree;
   logic                     fifoPop;
   logic                     fifoFull;
   logic                     fifoEmpty;
   logic [CNT_W-1:0]         fifoCount;
   logic                     fifoEmptyNext;

   assign inRange  = (bus.aPixelAddr < 32'(FRAME_PIXELS));
   assign bankAddr = bus.aPixelAddr[FB_ADDR_WIDTH-1:0] + (bufferSelect_q ? BANK_OFFSET : '0);
   assign pushEntry.addr = ENTRY_ADDR_W'(bankAddr);
   assign pushEntry.data = bus.aPixelData;

   // A full FIFO stalls the pixel instead of dropping it, so drops need space too.
   assign pushReq   = bus.aPixelWrite && !fifoFull && (state_q != DONE) && inRange;
   assign dropPixel = bus.aPixelWrite && !fifoFull && ((state_q == DONE) || !inRange);

   assign slotFree = !slotValid_q || bus.aFbReady;
   assign fifoPop  = slotFree && !fifoEmpty;

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_pixel_fifo (
      .clk_i   (aClock),
      .rst_ni  (aReset),
      .push_i  (pushReq),
      .pop_i   (fifoPop),
      .data_i  (pushEntry),
      .data_o  (headEntry),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   assign fifoEmptyNext = ((fifoCount == '0) && !pushReq) ||
                          ((fifoCount == CNT_W'(1)) && fifoPop && !pushReq);

   always_comb begin
      slotValid_d = slotValid_q;
      slot_d      = slot_q;
      errorFlag_d = errorFlag_q || dropPixel;
      if (slotFree) begin
         slotValid_d = !fifoEmpty;
         slot_d      = fifoEmpty ? '0 : headEntry;
      end
   end

   // Draining completes on the edge that leaves both the FIFO and the slot empty.
   always_comb begin
      state_d        = state_q;
      bufferSelect_d = bufferSelect_q;
      unique case (state_q)
         DRAWING:  if (aFrameDone) state_d = DRAINING;
         DRAINING: if (fifoEmptyNext && !slotValid_d) state_d = DONE;
         DONE: begin
            if (aFrameFlipped) begin
               state_d        = DRAWING;
               bufferSelect_d = !bufferSelect_q;
            end
         end
         default:  state_d = DRAWING;
      endcase
   end

   always_ff @(posedge aClock or negedge aReset) begin
      if (!aReset) begin
         state_q        <= DRAWING;
         bufferSelect_q <= 1'b0;
         errorFlag_q    <= 1'b0;
         slotValid_q    <= 1'b0;
         slot_q         <= '0;
      end else begin
         state_q        <= state_d;
         bufferSelect_q <= bufferSelect_d;
         errorFlag_q    <= errorFlag_d;
         slotValid_q    <= slotValid_d;
         slot_q         <= slot_d;
      end
   end

   assign bus.anOutStall   = fifoFull;
   assign bus.anOutFbWrite = slotValid_q;
   assign bus.anOutFbAddr  = FB_ADDR_WIDTH'(slot_q.addr);
   assign bus.anOutFbData  = slot_q.data;

   assign anOutFrameDone    = (state_q == DONE);
   assign anOutBufferSelect = bufferSelect_q;
   assign anOutAddrError    = errorFlag_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed and randomized checks of framebuffer_writer against a queue-based
// model of pending pixels, frame progress and buffer selection.
module tb_framebuffer_writer;
   import illusion_pkg::*;

   localparam int          DEPTH        = 8;
   localparam int          FBW          = 18;
   localparam int unsigned FRAME_PIXELS = 32'(FB_SIZE);
   localparam int          M_DRAW       = 0;
   localparam int          M_DRAIN      = 1;
   localparam int          M_DONE       = 2;

   typedef struct {
      int unsigned addr;
      int unsigned data;
   } px_t;

   logic aClock = 1'b0;
   logic aReset = 1'b0;
   logic aFrameDone = 1'b0;
   logic aFrameFlipped = 1'b0;
   logic anOutFrameDone;
   logic anOutBufferSelect;
   logic anOutAddrError;

   framebuffer_writer_if #(.FB_ADDR_WIDTH(FBW)) bus ();

   framebuffer_writer #(
      .FIFO_DEPTH       (DEPTH),
      .RENDERING_WIDTH  (320),
      .RENDERING_HEIGHT (240),
      .FB_ADDR_WIDTH    (FBW)
   ) dut (
      .aClock            (aClock),
      .aReset            (aReset),
      .bus               (bus),
      .aFrameDone        (aFrameDone),
      .aFrameFlipped     (aFrameFlipped),
      .anOutFrameDone    (anOutFrameDone),
      .anOutBufferSelect (anOutBufferSelect),
      .anOutAddrError    (anOutAddrError)
   );

   always #5 aClock = ~aClock;

   px_t mFifo[$];
   px_t mSlot;
   bit  mSlotV;
   int  mState;
   bit  mSel;
   bit  mErr;
   bit  mAccepted;
   px_t obsLog[$];
   int  assertCount;
   int  failCount;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mFifo.delete();
      mSlotV    = 1'b0;
      mSlot     = '{0, 0};
      mState    = M_DRAW;
      mSel      = 1'b0;
      mErr      = 1'b0;
      mAccepted = 1'b0;
   endtask

   // One clock edge of the intended behaviour, using pre-edge inputs and state.
   task automatic modelEdge();
      bit          wr;
      int unsigned a;
      int          sizeBefore;
      wr         = bus.aPixelWrite;
      a          = bus.aPixelAddr;
      sizeBefore = mFifo.size();
      mAccepted  = wr && (sizeBefore < DEPTH) && (mState != M_DONE) && (a < FRAME_PIXELS);
      if (wr && (sizeBefore < DEPTH) && ((mState == M_DONE) || (a >= FRAME_PIXELS))) mErr = 1'b1;
      if (!mSlotV || bus.aFbReady) begin
         if (sizeBefore > 0) begin
            mSlot  = mFifo.pop_front();
            mSlotV = 1'b1;
         end else begin
            mSlotV = 1'b0;
         end
      end
      if (mAccepted) mFifo.push_back('{a + (mSel ? FRAME_PIXELS : 0), 32'(bus.aPixelData)});
      case (mState)
         M_DRAW:  if (aFrameDone) mState = M_DRAIN;
         M_DRAIN: if (mFifo.size() == 0 && !mSlotV) mState = M_DONE;
         M_DONE: begin
            if (aFrameFlipped) begin
               mState = M_DRAW;
               mSel   = !mSel;
            end
         end
         default: mState = M_DRAW;
      endcase
   endtask

   task automatic checkOutput();
      check("stall",     32'(bus.anOutStall),   32'(mFifo.size() == DEPTH));
      check("fbWrite",   32'(bus.anOutFbWrite), 32'(mSlotV));
      if (mSlotV) begin
         check("fbAddr", 32'(bus.anOutFbAddr),  mSlot.addr);
         check("fbData", 32'(bus.anOutFbData),  mSlot.data);
      end
      check("frameDone", 32'(anOutFrameDone),    32'(mState == M_DONE));
      check("bufSel",    32'(anOutBufferSelect), 32'(mSel));
      check("addrErr",   32'(anOutAddrError),    32'(mErr));
      if (bus.anOutFbWrite === 1'b1 && bus.aFbReady === 1'b1)
         obsLog.push_back('{32'(bus.anOutFbAddr), 32'(bus.anOutFbData)});
   endtask

   task automatic applyStimulus(input bit wr, input int unsigned addr, input int unsigned data,
                                input bit ready);
      bus.aPixelWrite = wr;
      bus.aPixelAddr  = addr;
      bus.aPixelData  = 3'(data);
      bus.aFbReady    = ready;
      checkOutput();
      modelEdge();
      @(posedge aClock);
      @(negedge aClock);
   endtask

   task automatic checkResetZero(input string tag);
      check({tag, ".stall"},     32'(bus.anOutStall),      0);
      check({tag, ".fbWrite"},   32'(bus.anOutFbWrite),    0);
      check({tag, ".fbAddr"},    32'(bus.anOutFbAddr),     0);
      check({tag, ".fbData"},    32'(bus.anOutFbData),     0);
      check({tag, ".frameDone"}, 32'(anOutFrameDone),      0);
      check({tag, ".bufSel"},    32'(anOutBufferSelect),   0);
      check({tag, ".addrErr"},   32'(anOutAddrError),      0);
   endtask

   // Asynchronous reset applied between clock edges, released a cycle later.
   task automatic doAsyncReset(input string tag);
      aReset = 1'b0;
      #1;
      checkResetZero(tag);
      modelReset();
      @(negedge aClock);
      aReset = 1'b1;
   endtask

   task automatic drainAll();
      for (int k = 0; k < 40 && (mFifo.size() > 0 || mSlotV); k++) applyStimulus(0, 0, 0, 1);
   endtask

   initial begin
      int base;
      int idx;
      int unsigned addr;
      int unsigned r;

      assertCount = 0;
      failCount   = 0;
      bus.aPixelWrite = 1'b0;
      bus.aPixelAddr  = '0;
      bus.aPixelData  = '0;
      bus.aFbReady    = 1'b0;
      modelReset();
      repeat (2) @(negedge aClock);
      checkResetZero("reset");
      aReset = 1'b1;
      @(negedge aClock);

      $display("[TB] single pixel");
      base = obsLog.size();
      applyStimulus(1, 100, 5, 1);
      applyStimulus(0, 0, 0, 1);
      check("single.write", 32'(bus.anOutFbWrite), 1);
      check("single.addr",  32'(bus.anOutFbAddr),  100);
      check("single.data",  32'(bus.anOutFbData),  5);
      applyStimulus(0, 0, 0, 1);
      check("single.count", obsLog.size() - base, 1);
      check("single.err",   32'(anOutAddrError), 0);

      $display("[TB] backpressure");
      base = obsLog.size();
      idx  = 0;
      for (int k = 0; k < 30 && idx < 9; k++) begin
         applyStimulus(1, 200 + idx, idx % 8, 0);
         if (mAccepted) idx++;
      end
      for (int k = 0; k < 3; k++) begin
         check("bp.stall", 32'(bus.anOutStall), 1);
         applyStimulus(1, 209, 1, 0);
      end
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1, 209, 1, 1);
         if (mAccepted) break;
      end
      drainAll();
      check("bp.count", obsLog.size() - base, 10);
      for (int k = 0; k < 10 && base + k < obsLog.size(); k++)
         check("bp.order", obsLog[base + k].addr, 200 + k);

      $display("[TB] range boundary and drop");
      base = obsLog.size();
      applyStimulus(1, 76799, 2, 1);
      drainAll();
      check("edge.count", obsLog.size() - base, 1);
      check("edge.err",   32'(anOutAddrError), 0);
      base = obsLog.size();
      applyStimulus(1, 76800, 3, 1);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1);
      check("drop.count", obsLog.size() - base, 0);
      check("drop.err",   32'(anOutAddrError), 1);
      applyStimulus(1, 50, 4, 1);
      drainAll();
      check("drop.sticky", 32'(anOutAddrError), 1);

      $display("[TB] frame handshake");
      for (int k = 0; k < 3; k++) applyStimulus(1, 300 + k, k, 0);
      aFrameDone = 1'b1;
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         check("frame.pending", 32'(anOutFrameDone), 0);
         applyStimulus(0, 0, 0, 1);
      end
      check("frame.done", 32'(anOutFrameDone), 1);
      aFrameDone = 1'b0;
      applyStimulus(0, 0, 0, 1);

      $display("[TB] flip");
      aFrameFlipped = 1'b1;
      applyStimulus(0, 0, 0, 1);
      aFrameFlipped = 1'b0;
      check("flip.sel",  32'(anOutBufferSelect), 1);
      check("flip.done", 32'(anOutFrameDone),    0);
      applyStimulus(1, 10, 6, 1);
      applyStimulus(0, 0, 0, 1);
      check("flip.addr", 32'(bus.anOutFbAddr), 76810);
      check("flip.data", 32'(bus.anOutFbData), 6);
      drainAll();

      $display("[TB] reset mid-drain");
      for (int k = 0; k < 5; k++) applyStimulus(1, 400 + k, k, 0);
      aFrameDone = 1'b1;
      applyStimulus(0, 0, 0, 0);
      aFrameDone = 1'b0;
      doAsyncReset("midReset");
      base = obsLog.size();
      for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1);
      check("midReset.writes", obsLog.size() - base, 0);
      check("midReset.sel",    32'(anOutBufferSelect), 0);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 1200; c++) begin
         if (c == 600) doAsyncReset("randReset");
         r = $urandom_range(0, 99);
         if (r < 3)      addr = FRAME_PIXELS + $urandom_range(0, 400);
         else if (r < 6) addr = FRAME_PIXELS - 1;
         else            addr = $urandom_range(0, FRAME_PIXELS - 1);
         aFrameDone    = ($urandom_range(0, 39) == 0);
         aFrameFlipped = ($urandom_range(0, 7) == 0);
         applyStimulus($urandom_range(0, 99) < 70, addr, $urandom_range(0, 7),
                       $urandom_range(0, 99) < 60);
      end
      aFrameDone    = 1'b0;
      aFrameFlipped = 1'b0;
      drainAll();
      applyStimulus(0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
